// File: rtl/bsg_chip_pkg.sv
// Shared types for the SDR link reset sequencer: per-link state enum, phase-output
// encoding and the counter-width helper.
package bsg_chip_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAssert,
        StToken,
        StRelUp,
        StRelDown,
        StRelDs,
        StDone
    } bsg_sdr_reset_seq_state_e;

    typedef struct packed {
        logic up;
        logic down;
        logic ds;
        logic token;
    } bsg_sdr_reset_phase_s;

    localparam bsg_sdr_reset_phase_s ResetPhase = '{1'b1, 1'b1, 1'b1, 1'b0};

    function automatic int unsigned safe_clog2(input int unsigned x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    function automatic bsg_sdr_reset_seq_state_e next_phase(input bsg_sdr_reset_seq_state_e st);
        case (st)
            StAssert:  return StToken;
            StToken:   return StRelUp;
            StRelUp:   return StRelDown;
            StRelDown: return StRelDs;
            default:   return StDone;
        endcase
    endfunction

    function automatic bsg_sdr_reset_phase_s phase_outputs(input bsg_sdr_reset_seq_state_e st);
        case (st)
            StIdle:    return ResetPhase;
            StAssert:  return '{1'b1, 1'b1, 1'b1, 1'b0};
            StToken:   return '{1'b1, 1'b1, 1'b1, 1'b1};
            StRelUp:   return '{1'b0, 1'b1, 1'b1, 1'b0};
            StRelDown: return '{1'b0, 1'b0, 1'b1, 1'b0};
            default:   return '{1'b0, 1'b0, 1'b0, 1'b0};
        endcase
    endfunction

endpackage

// File: rtl/bsg_sdr_link_reset_fsm.sv
// Per-link reset sequencer FSM with phase counter; outputs are registered from next state.
// BSG_SDR_RESET_SEQ_STATUS_EN adds a DONE-entry pulse for the status counters.
module bsg_sdr_link_reset_fsm
    import bsg_chip_pkg::*;
#(
    parameter int unsigned hold_cycles_p = 16,
    parameter int unsigned lg_hold_lp    = safe_clog2(hold_cycles_p + 1)
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic start_v_i,
    output logic token_reset_o,
    output logic uplink_reset_o,
    output logic downlink_reset_o,
    output logic downstream_reset_o,
    output logic done_o,
    output logic busy_o
`ifdef BSG_SDR_RESET_SEQ_STATUS_EN
    ,
    output logic seq_done_o
`endif
);

    localparam logic [lg_hold_lp-1:0] Reload = lg_hold_lp'(hold_cycles_p - 1);

    bsg_sdr_reset_seq_state_e state_q, state_d;
    logic [lg_hold_lp-1:0]    cnt_q, cnt_d;
    bsg_sdr_reset_phase_s     phase_q, phase_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start_v_i) begin
            // A new edge always restarts, aborting any sequence in flight.
            state_d = StAssert;
            cnt_d   = Reload;
        end else if (state_q != StIdle && state_q != StDone) begin
            if (cnt_q == '0) begin
                state_d = next_phase(state_q);
                cnt_d   = Reload;
            end else begin
                cnt_d = cnt_q - lg_hold_lp'(1);
            end
        end
        phase_d = (state_d == StIdle) ? phase_q : phase_outputs(state_d);
        done_d  = (state_d == StDone);
        busy_d  = (state_d != StIdle) && (state_d != StDone);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            phase_q <= ResetPhase;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign token_reset_o      = phase_q.token;
    assign uplink_reset_o     = phase_q.up;
    assign downlink_reset_o   = phase_q.down;
    assign downstream_reset_o = phase_q.ds;
    assign done_o             = done_q;
    assign busy_o             = busy_q;

`ifdef BSG_SDR_RESET_SEQ_STATUS_EN
    assign seq_done_o = (state_d == StDone) && (state_q != StDone);
`endif

endmodule

// File: rtl/bsg_sdr_link_reset_sequencer.sv
// Multi-link SDR reset sequencer: start edge detect, per-link FSMs, busy reduction.
// BSG_SDR_RESET_SEQ_STATUS_EN adds per-link sequence counters and sticky abort flags.
module bsg_sdr_link_reset_sequencer
    import bsg_chip_pkg::*;
#(
    parameter int unsigned num_links_p   = 3,
    parameter int unsigned hold_cycles_p = 16,
    parameter int unsigned lg_hold_lp    = safe_clog2(hold_cycles_p + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [num_links_p-1:0] start_i,
    output logic [num_links_p-1:0] token_reset_o,
    output logic [num_links_p-1:0] uplink_reset_o,
    output logic [num_links_p-1:0] downlink_reset_o,
    output logic [num_links_p-1:0] downstream_reset_o,
    output logic [num_links_p-1:0] done_o,
    output logic                   busy_o
`ifdef BSG_SDR_RESET_SEQ_STATUS_EN
    ,
    output logic [num_links_p-1:0][7:0] seq_count_o,
    output logic [num_links_p-1:0]      aborted_o
`endif
);

    logic [num_links_p-1:0] start_r_q;
    logic [num_links_p-1:0] start_v;
    logic [num_links_p-1:0] link_busy;
`ifdef BSG_SDR_RESET_SEQ_STATUS_EN
    logic [num_links_p-1:0] seq_done;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            start_r_q <= '0;
        end else begin
            start_r_q <= start_i;
        end
    end

    assign start_v = start_i & ~start_r_q;
    assign busy_o  = |link_busy;

    for (genvar i = 0; i < num_links_p; i++) begin : g_link
        bsg_sdr_link_reset_fsm #(
            .hold_cycles_p (hold_cycles_p),
            .lg_hold_lp    (lg_hold_lp)
        ) u_fsm (
            .clk_i              (clk_i),
            .reset_n_i          (reset_n_i),
            .start_v_i          (start_v[i]),
            .token_reset_o      (token_reset_o[i]),
            .uplink_reset_o     (uplink_reset_o[i]),
            .downlink_reset_o   (downlink_reset_o[i]),
            .downstream_reset_o (downstream_reset_o[i]),
            .done_o             (done_o[i]),
            .busy_o             (link_busy[i])
`ifdef BSG_SDR_RESET_SEQ_STATUS_EN
            ,
            .seq_done_o         (seq_done[i])
`endif
        );
    end

`ifdef BSG_SDR_RESET_SEQ_STATUS_EN
    logic [num_links_p-1:0][7:0] seq_count_q, seq_count_d;
    logic [num_links_p-1:0]      aborted_q, aborted_d;

    always_comb begin
        for (int i = 0; i < num_links_p; i++) begin
            seq_count_d[i] = seq_count_q[i] + (seq_done[i] ? 8'd1 : 8'd0);
        end
        // link_busy is registered, so it reflects the state the edge arrives in.
        aborted_d = aborted_q | (start_v & link_busy);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            seq_count_q <= '0;
            aborted_q   <= '0;
        end else begin
            seq_count_q <= seq_count_d;
            aborted_q   <= aborted_d;
        end
    end

    assign seq_count_o = seq_count_q;
    assign aborted_o   = aborted_q;
`endif

endmodule

// File: tb/tb_bsg_sdr_link_reset_sequencer.sv
// Directed bench for bsg_sdr_link_reset_sequencer (hold_cycles_p=4, num_links_p=3).
// Status checks compile in when BSG_SDR_RESET_SEQ_STATUS_EN is defined.
module tb_bsg_sdr_link_reset_sequencer;

    localparam int unsigned NumLinks = 3;
    localparam int unsigned Hold     = 4;

    // Per-link expected bundle: {busy, done, token, ds, down, up}
    localparam logic [5:0] Rst = 6'b000111;
    localparam logic [5:0] Rel = 6'b010000;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NumLinks-1:0] start_i;
    logic [NumLinks-1:0] token_reset_o, uplink_reset_o, downlink_reset_o, downstream_reset_o;
    logic [NumLinks-1:0] done_o;
    logic                busy_o;
`ifdef BSG_SDR_RESET_SEQ_STATUS_EN
    logic [NumLinks-1:0][7:0] seq_count_o;
    logic [NumLinks-1:0]      aborted_o;
`endif

    int vectors     = 0;
    int miscompares = 0;

    bsg_sdr_link_reset_sequencer #(
        .num_links_p   (NumLinks),
        .hold_cycles_p (Hold)
    ) dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .start_i            (start_i),
        .token_reset_o      (token_reset_o),
        .uplink_reset_o     (uplink_reset_o),
        .downlink_reset_o   (downlink_reset_o),
        .downstream_reset_o (downstream_reset_o),
        .done_o             (done_o),
        .busy_o             (busy_o)
`ifdef BSG_SDR_RESET_SEQ_STATUS_EN
        ,
        .seq_count_o        (seq_count_o),
        .aborted_o          (aborted_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected link bundle c cycles after the start event was detected (hold = 4).
    function automatic logic [5:0] exp_link(input int c);
        logic up, down, ds, token, done, busy;
        up    = (c < 9);
        down  = (c < 13);
        ds    = (c < 17);
        token = (c >= 5) && (c <= 8);
        done  = (c >= 21);
        busy  = (c >= 1) && (c <= 20);
        return {busy, done, token, ds, down, up};
    endfunction

    task automatic chk_all(input string tag, input logic [5:0] e0, input logic [5:0] e1,
                           input logic [5:0] e2);
        chk({tag, " up"},    {5'b0, uplink_reset_o},     {5'b0, e2[0], e1[0], e0[0]});
        chk({tag, " down"},  {5'b0, downlink_reset_o},   {5'b0, e2[1], e1[1], e0[1]});
        chk({tag, " ds"},    {5'b0, downstream_reset_o}, {5'b0, e2[2], e1[2], e0[2]});
        chk({tag, " token"}, {5'b0, token_reset_o},      {5'b0, e2[3], e1[3], e0[3]});
        chk({tag, " done"},  {5'b0, done_o},             {5'b0, e2[4], e1[4], e0[4]});
        chk({tag, " busy"},  {7'b0, busy_o},             {7'b0, e0[5] | e1[5] | e2[5]});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        start_i = '0;
        @(negedge clk);
        chk_all("reset", Rst, Rst, Rst);
        tick(2);
        chk_all("reset_hold", Rst, Rst, Rst);
        reset_n = 1'b1;

        for (int c = 1; c <= 10; c++) begin
            tick(1);
            chk_all("idle", Rst, Rst, Rst);
        end

        // Single link sequence, then start held high must not retrigger.
        start_i = 3'b001;
        for (int c = 1; c <= 22; c++) begin
            tick(1);
            chk_all("single", exp_link(c), Rst, Rst);
        end
        tick(10);
        chk_all("held_high", Rel, Rst, Rst);

        // All three links in parallel.
        start_i = 3'b000;
        tick(1);
        start_i = 3'b111;
        for (int c = 1; c <= 22; c++) begin
            tick(1);
            chk_all("parallel", exp_link(c), exp_link(c), exp_link(c));
        end

        // Abort link 1 during REL_DOWN with a fresh rising edge.
        start_i = 3'b000;
        tick(1);
        start_i = 3'b010;
        for (int c = 1; c <= 14; c++) begin
            tick(1);
            if (c == 2) start_i = 3'b000;
            chk_all("abort_pre", Rel, exp_link(c), Rel);
        end
        start_i = 3'b010;
        for (int c = 1; c <= 22; c++) begin
            tick(1);
            chk_all("abort_post", Rel, exp_link(c), Rel);
        end
`ifdef BSG_SDR_RESET_SEQ_STATUS_EN
        chk("aborted", {5'b0, aborted_o}, 8'h02);
`endif

        // Asynchronous reset during TOKEN, start still high afterwards.
        start_i = 3'b000;
        tick(1);
        start_i = 3'b001;
        tick(6);
        chk_all("token_pre", exp_link(6), Rel, Rel);
        #2 reset_n = 1'b0;
        #1 chk_all("async_rst", Rst, Rst, Rst);
`ifdef BSG_SDR_RESET_SEQ_STATUS_EN
        chk("aborted_rst", {5'b0, aborted_o}, 8'h00);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick(1);
            chk_all("post_rst", exp_link(c), Rst, Rst);
        end

`ifdef BSG_SDR_RESET_SEQ_STATUS_EN
        // 257 completed sequences on link 0 wrap the counter to 1.
        reset_n = 1'b0;
        start_i = 3'b000;
        tick(1);
        reset_n = 1'b1;
        tick(1);
        for (int s = 1; s <= 257; s++) begin
            start_i = 3'b001;
            tick(21);
            if (s == 1) chk("count_first", seq_count_o[0], 8'd1);
            start_i = 3'b000;
            tick(1);
        end
        chk("count_wrap", seq_count_o[0], 8'd1);
        chk("count_l1", seq_count_o[1], 8'd0);
        chk("count_l2", seq_count_o[2], 8'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bsg_sdr_link_reset_sequencer.md
BSG_SDR_LINK_RESET_SEQUENCER -- requirements
Module: bsg_sdr_link_reset_sequencer

Interface
REQ-001 Parameter num_links_p, default 3: number of independent SDR links sequenced.
REQ-002 Parameter hold_cycles_p, default 16: length of each sequence phase in cycles; legal range 1..65535.
REQ-003 Parameter lg_hold_lp, derived as `BSG_SAFE_CLOG2(hold_cycles_p+1)`: phase counter width.
REQ-004 The clock port SHALL be: clk_i  input  1  the single clock; every flop is on its rising edge.
REQ-005 The reset port SHALL be: reset_n_i  input  1  asynchronous, active-low reset.
REQ-006 The port start_i SHALL be: start_i  input  num_links_p  per-link sequence request, level, sampled on clk_i.
REQ-007 The port token_reset_o SHALL be: token_reset_o  output  num_links_p  per-link SDR token reset, active-high.
REQ-008 The port uplink_reset_o SHALL be: uplink_reset_o  output  num_links_p  per-link SDR uplink reset, active-high.
REQ-009 The port downlink_reset_o SHALL be: downlink_reset_o  output  num_links_p  per-link SDR downlink reset, active-high.
REQ-010 The port downstream_reset_o SHALL be: downstream_reset_o  output  num_links_p  per-link SDR downstream reset, active-high.
REQ-011 The port done_o SHALL be: done_o  output  num_links_p  per-link flag; 1 means the sequence has completed and the link is released.
REQ-012 The port busy_o SHALL be: busy_o  output  1  OR of all per-link "FSM not in IDLE/DONE" bits.

Function
REQ-013 Each link SHALL have an independent FSM with states IDLE, ASSERT, TOKEN, REL_UP, REL_DOWN, REL_DS, DONE.
REQ-014 Each FSM SHALL detect a start event as start_i[i] & ~start_r[i], where start_r is start_i registered one cycle.
REQ-015 On a start event, the FSM SHALL enter ASSERT on the next edge and load the phase counter with hold_cycles_p-1.
REQ-016 The FSM SHALL spend exactly hold_cycles_p cycles in each state ASSERT, TOKEN, REL_UP, REL_DOWN, REL_DS.
REQ-017 The FSM SHALL advance when the counter is 0 and reload the counter to hold_cycles_p-1 on each transition.
REQ-018 Phase order SHALL be ASSERT -> TOKEN -> REL_UP -> REL_DOWN -> REL_DS -> DONE.
REQ-019 The outputs SHALL be registered and take these values (up/down/ds/token):
- ASSERT: 1/1/1/0
- TOKEN: 1/1/1/1
- REL_UP: 0/1/1/0
- REL_DOWN: 0/0/1/0
- REL_DS and DONE: 0/0/0/0
REQ-020 In IDLE, the outputs SHALL hold their last values.
REQ-021 done_o[i] SHALL be 1 only in DONE, which is entered 5*hold_cycles_p+1 cycles after the cycle in which the start event is detected.
REQ-022 DONE SHALL persist until the next start event.
REQ-023 A start event in any non-IDLE state, including mid-sequence, SHALL abort the sequence and restart at ASSERT with a full counter and done_o low.
REQ-024 Simultaneous start events on several links SHALL proceed fully in parallel with no arbitration.
REQ-025 start_i held high SHALL trigger exactly one sequence; a new sequence needs a 0 -> 1 transition.

Reset
REQ-026 While reset_n_i=0, all FSMs SHALL be IDLE with counter 0 and start_r=0.
REQ-027 While reset_n_i=0, the outputs SHALL be: uplink/downlink/downstream reset outputs 1, token_reset_o 0, done_o 0, busy_o 0.
REQ-028 Assertion of reset_n_i mid-sequence SHALL take effect asynchronously and return the block to the REQ-026/027 values.
REQ-029 After reset_n_i releases, start_i already high SHALL count as a start event on the first clock edge, because start_r was 0.

Configuration
REQ-030 With macro BSG_SDR_RESET_SEQ_STATUS_EN defined, the block SHALL add:
- output seq_count_o [num_links_p][7:0]: per-link count of completed sequences, +1 on DONE entry, wrapping 255 -> 0, reset 0.
- output aborted_o [num_links_p]: sticky, set on a REQ-023 abort, cleared on reset.
REQ-031 Without BSG_SDR_RESET_SEQ_STATUS_EN, those ports and their flops SHALL not exist and all other behaviour SHALL be identical.

Structure
REQ-032 The state enum bsg_sdr_reset_seq_state_e and the phase-output encoding SHALL live in bsg_chip_pkg.
REQ-033 The per-link FSM plus counter SHALL be a sub-module bsg_sdr_link_reset_fsm, instantiated num_links_p times in a generate loop.
REQ-034 The top level SHALL contain only start edge detection, the busy_o OR-reduction and the optional status logic.

Verification (hold_cycles_p=4, num_links_p=3)
REQ-035 Release reset, start_i=0 for 10 cycles -> up/down/ds=1, token=0, done_o=0, busy_o=0 throughout.
REQ-036 Raise start_i[0] at cycle T (event detected at T) -> outputs:
- token=1 for cycles T+5..T+8.
- up=0 from T+9, down=0 from T+13, ds=0 from T+17.
- done_o[0]=1 at T+21.
- links 1 and 2 unchanged.
REQ-037 Raise start_i[2:0]=3'b111 in the same cycle -> all three links produce identical waveforms and done_o=3'b111 together.
REQ-038 Toggle start_i[1] 0 -> 1 again during REL_DOWN -> up/down/ds return to 1, done_o[1]=1 exactly 21 cycles after the new edge, aborted_o[1]=1 when the macro is enabled.
REQ-039 Drive reset_n_i=0 for 1 cycle during TOKEN -> immediate return to reset values; with start_i still high, a fresh sequence starts on the first edge after release.
REQ-040 With the macro enabled, run 257 complete sequences on link 0 -> seq_count_o[0]=1.
